// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and widths for the regfile write arbiter
package regfile_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {CLEAR, RUN} state_e;
  typedef enum logic {REQ_A, REQ_B} req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with the pointer held internally
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_e ptr_q, ptr_d;

  // A lone requester is granted regardless of ptr; at most one side accepts per edge.
  always_comb begin
    gnt_a = en && (!req_b || ptr_q == REQ_A);
    gnt_b = en && (!req_a || ptr_q == REQ_B);
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_a && req_a) ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - clears the regfile after reset, then arbitrates two writeback requesters
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  ReqA_Valid,
  input  logic [REG_ADDR_W-1:0] ReqA_Reg,
  input  logic [REG_DATA_W-1:0] ReqA_Data,
  output logic                  ReqA_Ready,
  input  logic                  ReqB_Valid,
  input  logic [REG_ADDR_W-1:0] ReqB_Reg,
  input  logic [REG_DATA_W-1:0] ReqB_Data,
  output logic                  ReqB_Ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [REG_DATA_W-1:0] WriteData,
  output logic                  InitDone
);

  localparam int     CLR_W       = REG_ADDR_W + 1;
  localparam logic [CLR_W-1:0] CLR_END = CLR_W'(NUM_REGS);
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_e                  state_q, state_d;
  logic [CLR_W-1:0]        clr_idx_q, clr_idx_d;
  logic                    reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0]   write_register_q, write_register_d;
  logic [REG_DATA_W-1:0]   write_data_q, write_data_d;
  logic                    init_done_q, init_done_d;

  logic gnt_a, gnt_b;
  logic accept_a, accept_b;

  assign accept_a = ReqA_Valid && gnt_a;
  assign accept_b = ReqB_Valid && gnt_b;

  rr_arbiter2 u_arb (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .req_a  (ReqA_Valid),
    .req_b  (ReqB_Valid),
    .en     (state_q == RUN),
    .accept (accept_a || accept_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  always_comb begin
    state_d          = state_q;
    clr_idx_d        = clr_idx_q;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    init_done_d      = init_done_q;
    case (state_q)
      CLEAR: begin
        // clr_idx is one wider than an address so it can reach NUM_REGS as the end marker.
        if (clr_idx_q == CLR_END) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          reg_write_d      = 1'b1;
          write_register_d = clr_idx_q[REG_ADDR_W-1:0];
          write_data_d     = '0;
          clr_idx_d        = clr_idx_q + 1'b1;
        end
      end
      RUN: begin
        init_done_d = 1'b1;
        if (accept_a) begin
          reg_write_d      = (ReqA_Reg != REG_ZERO);
          write_register_d = ReqA_Reg;
          write_data_d     = ReqA_Data;
        end else if (accept_b) begin
          reg_write_d      = (ReqB_Reg != REG_ZERO);
          write_register_d = ReqB_Reg;
          write_data_d     = ReqB_Data;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= RESET_STATE;
      clr_idx_q        <= CLR_W'(1);
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      init_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      clr_idx_q        <= clr_idx_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      init_done_q      <= init_done_d;
    end
  end

  assign ReqA_Ready    = gnt_a;
  assign ReqB_Ready    = gnt_b;
  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;
  assign InitDone      = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst0_n = 1'b0;

  logic        ReqA_Valid = 1'b0, ReqB_Valid = 1'b0;
  logic [4:0]  ReqA_Reg = '0, ReqB_Reg = '0;
  logic [31:0] ReqA_Data = '0, ReqB_Data = '0;
  logic        ReqA_Ready, ReqB_Ready, RegWrite, InitDone;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  logic        a0_valid = 1'b0, b0_valid = 1'b0;
  logic [4:0]  a0_reg = '0, b0_reg = '0;
  logic [31:0] a0_data = '0, b0_data = '0;
  logic        a0_ready, b0_ready, rw0, idone0;
  logic [4:0]  wreg0;
  logic [31:0] wdata0;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  wr_t exp0_q[$];
  logic [31:0] model_mem [32];
  logic [31:0] shadow [32];
  logic [31:0] shadow0 [32];
  bit pref_a = 1'b1;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .Clk(clk), .Reset_n(rst_n),
    .ReqA_Valid(ReqA_Valid), .ReqA_Reg(ReqA_Reg), .ReqA_Data(ReqA_Data), .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid), .ReqB_Reg(ReqB_Reg), .ReqB_Data(ReqB_Data), .ReqB_Ready(ReqB_Ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData), .InitDone(InitDone)
  );

  regfile_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .Clk(clk), .Reset_n(rst0_n),
    .ReqA_Valid(a0_valid), .ReqA_Reg(a0_reg), .ReqA_Data(a0_data), .ReqA_Ready(a0_ready),
    .ReqB_Valid(b0_valid), .ReqB_Reg(b0_reg), .ReqB_Data(b0_data), .ReqB_Ready(b0_ready),
    .RegWrite(rw0), .WriteRegister(wreg0), .WriteData(wdata0), .InitDone(idone0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && RegWrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got reg %0d data %0h, expected no write", WriteRegister, WriteData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_reg", 32'(WriteRegister), 32'(e.r));
        chk("wr_data", WriteData, e.d);
      end
      shadow[WriteRegister] = WriteData;
    end
  end

  always @(negedge clk) begin : mon0
    wr_t e;
    if (rst0_n && rw0) begin
      if (exp0_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write0: got reg %0d data %0h, expected no write", wreg0, wdata0);
      end else begin
        e = exp0_q.pop_front();
        chk("wr0_reg", 32'(wreg0), 32'(e.r));
        chk("wr0_data", wdata0, e.d);
      end
      shadow0[wreg0] = wdata0;
    end
  end

  // Caller sits just after a rising edge; abort_at > 0 asserts reset after that clear write.
  task automatic clear_phase(input int abort_at);
    for (int k = 1; k < 32; k++) begin
      chk("clr_ready_a", 32'(ReqA_Ready), 0);
      chk("clr_ready_b", 32'(ReqB_Ready), 0);
      exp_q.push_back('{r: 5'(k), d: 32'd0});
      model_mem[k] = 32'd0;
      @(posedge clk); #1;
      if (k == abort_at) begin
        chk("abort_pre_rw", 32'(RegWrite), 1);
        chk("abort_pre_reg", 32'(WriteRegister), 32'(k));
        rst_n = 1'b0;
        #1;
        chk("async_rw", 32'(RegWrite), 0);
        chk("async_reg", 32'(WriteRegister), 0);
        chk("async_data", WriteData, 0);
        chk("async_idone", 32'(InitDone), 0);
        exp_q.delete();
        return;
      end
    end
    @(posedge clk); #1;
    chk("clr_initdone", 32'(InitDone), 1);
    chk("clr_end_rw", 32'(RegWrite), 0);
  endtask

  // One RUN cycle: reference decides the winner from valids and last-served history.
  task automatic run_cycle(output int win);
    @(negedge clk);
    win = 0;
    if (ReqA_Valid && ReqB_Valid) win = pref_a ? 1 : 2;
    else if (ReqA_Valid)          win = 1;
    else if (ReqB_Valid)          win = 2;
    if (ReqA_Valid) chk("ready_a", 32'(ReqA_Ready), 32'(win == 1));
    if (ReqB_Valid) chk("ready_b", 32'(ReqB_Ready), 32'(win == 2));
    if (win == 1) begin
      if (ReqA_Reg != 0) begin
        exp_q.push_back('{r: ReqA_Reg, d: ReqA_Data});
        model_mem[ReqA_Reg] = ReqA_Data;
      end
      pref_a = 1'b0;
    end else if (win == 2) begin
      if (ReqB_Reg != 0) begin
        exp_q.push_back('{r: ReqB_Reg, d: ReqB_Data});
        model_mem[ReqB_Reg] = ReqB_Data;
      end
      pref_a = 1'b1;
    end
    @(posedge clk); #1;
    if (win == 1) ReqA_Valid = 1'b0;
    if (win == 2) ReqB_Valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = (i == 0) ? 32'd0 : 32'hDEAD_0000 + 32'(i);
      shadow[i]    = model_mem[i];
      shadow0[i]   = model_mem[i];
    end
    a0_valid = 1'b1; a0_reg = 5'd17; a0_data = 32'd7;
    #23;
    chk("rst_rw", 32'(RegWrite), 0);
    chk("rst_reg", 32'(WriteRegister), 0);
    chk("rst_data", WriteData, 0);
    chk("rst_idone", 32'(InitDone), 0);
    chk("rst_ready_a", 32'(ReqA_Ready), 0);
    chk("rst0_idone", 32'(idone0), 0);

    @(negedge clk);
    chk("nc_ready_a", 32'(a0_ready), 1);
    exp0_q.push_back('{r: 5'd17, d: 32'd7});
    rst0_n = 1'b1;
    @(posedge clk); #1;
    chk("nc_idone", 32'(idone0), 1);
    a0_valid = 1'b0;
    @(posedge clk); #1;
    chk("nc_reg17", shadow0[17], 32'd7);
    chk("nc_idle_rw", 32'(rw0), 0);

    @(negedge clk);
    rst_n = 1'b1;
    pref_a = 1'b1;
    clear_phase(0);
    @(posedge clk); #1;
    chk("clr_reg5", shadow[5], model_mem[5]);
    chk("clr_reg31", shadow[31], model_mem[31]);

    ReqA_Valid = 1'b1; ReqA_Reg = 5'd2; ReqA_Data = 32'd42;
    run_cycle(w);
    chk("a_only_rw", 32'(RegWrite), 1);
    run_cycle(w);
    chk("a_only_reg2", shadow[2], 32'd42);

    ReqB_Valid = 1'b1; ReqB_Reg = 5'd6; ReqB_Data = 32'd66;
    run_cycle(w);

    for (int i = 0; i < 4; i++) begin
      ReqA_Valid = 1'b1; ReqA_Reg = 5'd3; ReqA_Data = 32'd9;
      ReqB_Valid = 1'b1; ReqB_Reg = 5'd4; ReqB_Data = 32'd15;
      run_cycle(w);
    end
    ReqA_Valid = 1'b0; ReqB_Valid = 1'b0;

    ReqA_Valid = 1'b1; ReqA_Reg = 5'd0; ReqA_Data = 32'd15;
    run_cycle(w);
    chk("r0_rw", 32'(RegWrite), 0);
    chk("r0_reg", 32'(WriteRegister), 0);
    chk("r0_data", WriteData, 32'd15);
    ReqA_Valid = 1'b1; ReqA_Reg = 5'd11; ReqA_Data = 32'd111;
    ReqB_Valid = 1'b1; ReqB_Reg = 5'd12; ReqB_Data = 32'd122;
    run_cycle(w);
    run_cycle(w);
    run_cycle(w);
    chk("r0_reads_zero", shadow[0], 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pref_a = 1'b1;
    clear_phase(10);
    ReqA_Valid = 1'b1; ReqA_Reg = 5'd8; ReqA_Data = 32'd88;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pref_a = 1'b1;
    clear_phase(0);
    run_cycle(w);

    repeat (400) begin
      if (!ReqA_Valid && $urandom_range(0, 2) != 0) begin
        ReqA_Valid = 1'b1; ReqA_Reg = 5'($urandom_range(0, 31)); ReqA_Data = $urandom;
      end
      if (!ReqB_Valid && $urandom_range(0, 2) != 0) begin
        ReqB_Valid = 1'b1; ReqB_Reg = 5'($urandom_range(0, 31)); ReqB_Data = $urandom;
      end
      run_cycle(w);
    end
    ReqA_Valid = 1'b0; ReqB_Valid = 1'b0;
    run_cycle(w);
    run_cycle(w);

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("exp0_q_drained", 32'(exp0_q.size()), 0);
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("regfile_%0d", r), shadow[r], model_mem[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 register file (`regfile`) between two writeback requesters: A (ALU writeback) and B (load writeback). After reset it sequences a clear pass that writes zero to registers 1..NUM_REGS-1. It then grants one valid/ready write per cycle, with round-robin fairness. It drives the regfile's `RegWrite`, `WriteRegister` and `WriteData` from registered outputs.

## Interface
- `NUM_REGS`, default 32: register count; address width is log2(NUM_REGS) = 5.
- `CLEAR_ON_RESET`, default 1: 1 runs the clear pass after reset; 0 enters RUN directly.

Ports:
- `Clk`, input, 1 bit: single clock, positive edge.
- `Reset_n`, input, 1 bit: asynchronous, active-low reset.
- `ReqA_Valid`, input, 1 bit: A has a write pending.
- `ReqA_Reg`, input, 5 bits: A destination register.
- `ReqA_Data`, input, 32 bits: A write data.
- `ReqA_Ready`, output, 1 bit: A is accepted on a rising edge where Valid and Ready are both 1.
- `ReqB_Valid`, `ReqB_Reg`, `ReqB_Data`, `ReqB_Ready`: same as the A ports, for requester B.
- `RegWrite`, output, 1 bit: to the regfile.
- `WriteRegister`, output, 5 bits: to the regfile.
- `WriteData`, output, 32 bits: to the regfile.
- `InitDone`, output, 1 bit: high once the block is in RUN.

## Operation
- States:
  - CLEAR: counter `clr_idx` runs from 1 to NUM_REGS-1.
  - RUN.
- CLEAR behaviour:
  - Each cycle loads outputs with RegWrite=1, WriteRegister=clr_idx, WriteData=0, then increments `clr_idx`.
  - On the edge after `clr_idx`=NUM_REGS-1 is issued: go to RUN, RegWrite<=0, InitDone<=1.
  - Register 0 is never written.
- Ready rules:
  - ReqA_Ready = RUN && (!ReqB_Valid || ptr==A).
  - ReqB_Ready = RUN && (!ReqA_Valid || ptr==B).
  - Both Ready signals are 0 in CLEAR.
- Round-robin pointer `ptr`:
  - Resets to A.
  - After any accepted request, `ptr` points to the other requester.
  - A lone valid requester is always granted, regardless of `ptr`.
- Accepted request: on the accepting edge, load WriteRegister=Reg and WriteData=Data, and set RegWrite=1 only if Reg≠0.
  - Writes to register 0 are accepted, discarded, and still advance `ptr`.
- No accept on an edge: RegWrite<=0. WriteRegister and WriteData hold their last values.
- Reset asserted at any time, including mid-CLEAR or mid-grant:
  - Outputs go to RegWrite=0, WriteRegister=0, WriteData=0, InitDone=0.
  - `ptr`=A, `clr_idx`=1.
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - With CLEAR_ON_RESET=0, InitDone is 1 from the first edge after release.
  - A pending write is lost. The requester retries because Valid is still held.

## Timing
- A request accepted at edge N drives the regfile during cycle N+1. The regfile captures it at edge N+1, giving a write latency of 1 cycle.
- Sustained throughput: one write per cycle. With both requesters continuously valid, grants alternate A, B, A, B…
- CLEAR duration is NUM_REGS-1 write cycles plus 1 transition edge. For NUM_REGS=32: 31 writes, InitDone high after edge 32 following reset release.
- Requesters must hold Valid, Reg and Data stable until accepted. Ready may change only with state, `ptr`, or the other requester's Valid.
- All outputs are registered; no combinational path from Req* to RegWrite, WriteRegister or WriteData.

## Structure
- Package `regfile_ctrl_pkg`:
  - state enum {CLEAR, RUN}.
  - `REG_ZERO`=5'd0.
  - `REG_ADDR_W`=5 and `REG_DATA_W`=32.
  - Requester id enum {REQ_A, REQ_B}.
- Sub-module `rr_arbiter2`:
  - Inputs: two request bits, an enable, and the accept strobe.
  - Outputs: two grant bits.
  - Holds `ptr` internally.
- Top level holds the CLEAR counter, the FSM and the output registers.

## Test plan
- Reset release with CLEAR_ON_RESET=1 and no requests:
  - 31 consecutive cycles with RegWrite=1, WriteRegister=1..31, WriteData=0.
  - Then InitDone=1 and RegWrite=0.
  - Reading regs 5 and 31 returns 0.
- A only, Reg=2, Data=42, after InitDone: ReqA_Ready=1; next cycle RegWrite=1, WriteRegister=2, WriteData=42; regfile reads 42.
- A and B held valid for 4 cycles (A: reg 3 / 9, B: reg 4 / 15): grants in order A, B, A, B; ports show 3/9, 4/15, 3/9, 4/15.
- A request with Reg=0, Data=15:
  - Accepted with RegWrite=0.
  - Reading reg 0 returns 0.
  - The next simultaneous A+B request grants B first.
- Reset_n pulsed low at cycle 10 of CLEAR:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, CLEAR restarts at WriteRegister=1.
- CLEAR_ON_RESET=0 with A valid, Reg=17, Data=7, during reset: accepted on the first edge after release; reg 17 reads 7 one cycle later.
